// File: rtl/josh_pkg.sv
// ---------------------------------------------------------------------------
// josh_pkg
// Shared definitions for the J.O.S.H. datapath control blocks.
//   - state_t   : frame scheduler state encoding (3 bits, also shown on LEDR)
//   - COORD_W   : pixel coordinate width
//   - COLOUR_W  : pixel colour width
//   - DEF_SCREEN_W / DEF_SCREEN_H : default clear-region size
// ---------------------------------------------------------------------------
package josh_pkg;

    localparam int COORD_W      = 8;
    localparam int COLOUR_W     = 3;
    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_WAIT  = 3'd2,
        S_PHYS  = 3'd3,
        S_SHIFT = 3'd4,
        S_WALL  = 3'd5,
        S_DUDE  = 3'd6,
        S_OVER  = 3'd7
    } state_t;

endpackage

// File: rtl/frame_ticker.sv
// ---------------------------------------------------------------------------
// frame_ticker
// Free-running wrap counter that produces the frame tick.
//   clk       : system clock
//   reset     : asynchronous active-high reset
//   i_enable  : count while high, hold while low
//   i_restart : force the count back to 0 (takes priority over counting)
//   o_tick    : high for the one cycle in which the count wraps
// ---------------------------------------------------------------------------
module frame_ticker #(
    parameter int CYCLES = 833333
) (
    input  logic clk,
    input  logic reset,
    input  logic i_enable,
    input  logic i_restart,
    output logic o_tick
);

    localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(CYCLES - 1);

    logic [W-1:0] r_count;
    logic         w_atLast;

    assign w_atLast = (r_count == LAST);

    // The tick is qualified with enable so a frozen counter sitting on its
    // last value does not keep firing.
    assign o_tick = i_enable && !i_restart && w_atLast;

    // Counts 0..CYCLES-1 and wraps; restart re-aligns the frame phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_restart) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= w_atLast ? '0 : r_count + 1'b1;
        end
    end

endmodule

// File: rtl/frame_scheduler.sv
// ---------------------------------------------------------------------------
// frame_scheduler
// Sequences one game frame: clear the screen when the game starts, then on
// each frame tick run physics, shift walls, draw walls and draw the dude.
// Owns the single VGA plot port and grants it to one pixel source at a time.
//   clk, reset                 : clock, asynchronous active-high reset
//   go, endgame                : run switch level, game-over level
//   phys_start / phys_done     : physics handshake (one-cycle pulses)
//   shift_start / shift_done   : wall shift handshake (one-cycle pulses)
//   wall_* / wall_ready        : wall pixel stream (valid/ready, last)
//   dude_* / dude_ready        : dude pixel stream (valid/ready, last)
//   plot, plot_x/y/colour      : registered VGA write port
//   state                      : current state, debug LEDs
//   frame_count                : completed frames, wraps
//   overrun                    : sticky, a tick arrived outside S_WAIT
// ---------------------------------------------------------------------------
module frame_scheduler
    import josh_pkg::*;
#(
    parameter int                    FRAME_CYCLES = 833333,
    parameter int                    SCREEN_W     = DEF_SCREEN_W,
    parameter int                    SCREEN_H     = DEF_SCREEN_H,
    parameter logic [COLOUR_W-1:0]   CLEAR_COLOUR = 3'b000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                go,
    input  logic                endgame,
    output logic                phys_start,
    input  logic                phys_done,
    output logic                shift_start,
    input  logic                shift_done,
    input  logic                wall_valid,
    input  logic                wall_last,
    input  logic [COORD_W-1:0]  wall_x,
    input  logic [COORD_W-1:0]  wall_y,
    input  logic [COLOUR_W-1:0] wall_colour,
    output logic                wall_ready,
    input  logic                dude_valid,
    input  logic                dude_last,
    input  logic [COORD_W-1:0]  dude_x,
    input  logic [COORD_W-1:0]  dude_y,
    input  logic [COLOUR_W-1:0] dude_colour,
    output logic                dude_ready,
    output logic                plot,
    output logic [COORD_W-1:0]  plot_x,
    output logic [COORD_W-1:0]  plot_y,
    output logic [COLOUR_W-1:0] plot_colour,
    output logic [2:0]          state,
    output logic [15:0]         frame_count,
    output logic                overrun
);

    localparam logic [COORD_W-1:0] LAST_X = COORD_W'(SCREEN_W - 1);
    localparam logic [COORD_W-1:0] LAST_Y = COORD_W'(SCREEN_H - 1);

    state_t               r_state;
    logic                 r_physStart;
    logic                 r_shiftStart;
    logic                 r_plot;
    logic [COORD_W-1:0]   r_plotX;
    logic [COORD_W-1:0]   r_plotY;
    logic [COLOUR_W-1:0]  r_plotColour;
    logic [15:0]          r_frameCount;
    logic                 r_overrun;
    logic [COORD_W-1:0]   r_clearX;
    logic [COORD_W-1:0]   r_clearY;

    logic w_tick;
    logic w_tickEnable;
    logic w_tickRestart;
    logic w_abort;
    logic w_wallFire;
    logic w_dudeFire;

    // Dropping go mid-frame abandons the frame from any working state.
    assign w_abort = !go && (r_state != S_IDLE) && (r_state != S_OVER);

    // Ready follows the state; it is also masked by go so that a stream
    // being abandoned loses its grant in the very cycle go falls, and no
    // beat is accepted that would never reach the plot port.
    assign wall_ready = (r_state == S_WALL) && go;
    assign dude_ready = (r_state == S_DUDE) && go;
    assign w_wallFire = wall_valid && wall_ready;
    assign w_dudeFire = dude_valid && dude_ready;

    assign w_tickEnable  = (r_state != S_IDLE) && (r_state != S_OVER);
    assign w_tickRestart = (r_state == S_IDLE) && go;

    frame_ticker #(
        .CYCLES   (FRAME_CYCLES)
    ) u_ticker (
        .clk       (clk),
        .reset     (reset),
        .i_enable  (w_tickEnable),
        .i_restart (w_tickRestart),
        .o_tick    (w_tick)
    );

    // Frame sequencer. All outputs are registered here; start pulses and
    // plot default low each cycle and are raised only on the cycle that
    // produces them. A tick seen anywhere but S_WAIT is discarded and
    // latched as an overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_physStart  <= 1'b0;
            r_shiftStart <= 1'b0;
            r_plot       <= 1'b0;
            r_plotX      <= '0;
            r_plotY      <= '0;
            r_plotColour <= '0;
            r_frameCount <= '0;
            r_overrun    <= 1'b0;
            r_clearX     <= '0;
            r_clearY     <= '0;
        end else begin
            r_plot       <= 1'b0;
            r_physStart  <= 1'b0;
            r_shiftStart <= 1'b0;

            if (w_tick && (r_state != S_WAIT)) begin
                r_overrun <= 1'b1;
            end

            if (w_abort) begin
                r_state  <= S_IDLE;
                r_clearX <= '0;
                r_clearY <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_clearX <= '0;
                        r_clearY <= '0;
                        if (go) begin
                            r_state <= S_CLEAR;
                        end
                    end

                    S_CLEAR: begin
                        r_plot       <= 1'b1;
                        r_plotX      <= r_clearX;
                        r_plotY      <= r_clearY;
                        r_plotColour <= CLEAR_COLOUR;
                        if (r_clearX == LAST_X) begin
                            r_clearX <= '0;
                            if (r_clearY == LAST_Y) begin
                                r_clearY <= '0;
                                r_state  <= S_WAIT;
                            end else begin
                                r_clearY <= r_clearY + 1'b1;
                            end
                        end else begin
                            r_clearX <= r_clearX + 1'b1;
                        end
                    end

                    S_WAIT: begin
                        if (w_tick) begin
                            r_state     <= S_PHYS;
                            r_physStart <= 1'b1;
                        end
                    end

                    S_PHYS: begin
                        if (phys_done) begin
                            if (endgame) begin
                                r_state <= S_OVER;
                            end else begin
                                r_state      <= S_SHIFT;
                                r_shiftStart <= 1'b1;
                            end
                        end
                    end

                    S_SHIFT: begin
                        if (shift_done) begin
                            r_state <= endgame ? S_OVER : S_WALL;
                        end
                    end

                    S_WALL: begin
                        if (w_wallFire) begin
                            r_plot       <= 1'b1;
                            r_plotX      <= wall_x;
                            r_plotY      <= wall_y;
                            r_plotColour <= wall_colour;
                            if (wall_last) begin
                                r_state <= S_DUDE;
                            end
                        end
                    end

                    S_DUDE: begin
                        if (w_dudeFire) begin
                            r_plot       <= 1'b1;
                            r_plotX      <= dude_x;
                            r_plotY      <= dude_y;
                            r_plotColour <= dude_colour;
                            if (dude_last) begin
                                r_state      <= S_WAIT;
                                r_frameCount <= r_frameCount + 1'b1;
                            end
                        end
                    end

                    S_OVER: begin
                        if (!go) begin
                            r_state <= S_IDLE;
                        end
                    end

                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign state       = r_state;
    assign phys_start  = r_physStart;
    assign shift_start = r_shiftStart;
    assign plot        = r_plot;
    assign plot_x      = r_plotX;
    assign plot_y      = r_plotY;
    assign plot_colour = r_plotColour;
    assign frame_count = r_frameCount;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_frame_scheduler
// Self-checking bench for frame_scheduler with a small screen and a short
// frame so that whole frames fit in a few hundred cycles.
// ---------------------------------------------------------------------------
module tb_frame_scheduler;

    localparam int FC = 32;
    localparam int SW = 4;
    localparam int SH = 3;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_PHYS  = 3'd3;
    localparam logic [2:0] ST_SHIFT = 3'd4;
    localparam logic [2:0] ST_WALL  = 3'd5;
    localparam logic [2:0] ST_DUDE  = 3'd6;
    localparam logic [2:0] ST_OVER  = 3'd7;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        go = 1'b0, endgame = 1'b0;
    logic        phys_done = 1'b0, shift_done = 1'b0;
    logic        wall_valid = 1'b0, wall_last = 1'b0;
    logic [7:0]  wall_x = '0, wall_y = '0;
    logic [2:0]  wall_colour = '0;
    logic        dude_valid = 1'b0, dude_last = 1'b0;
    logic [7:0]  dude_x = '0, dude_y = '0;
    logic [2:0]  dude_colour = '0;
    logic        phys_start, shift_start, wall_ready, dude_ready;
    logic        plot;
    logic [7:0]  plot_x, plot_y;
    logic [2:0]  plot_colour;
    logic [2:0]  state;
    logic [15:0] frame_count;
    logic        overrun;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic [2:0] colour;
        int         cycle;
    } pix_t;

    typedef struct {
        logic       go;
        logic       endgame;
        logic       physDone;
        logic       shiftDone;
        logic [2:0] expState;
        logic       expShiftStart;
    } vec_t;

    pix_t plotQ[$];
    pix_t expPix;
    vec_t vecs[7];
    int   compared   = 0;
    int   mismatched = 0;
    int   edgeCount  = 0;
    int   tickAt;

    frame_scheduler #(
        .FRAME_CYCLES (FC),
        .SCREEN_W     (SW),
        .SCREEN_H     (SH),
        .CLEAR_COLOUR (3'b000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .go          (go),
        .endgame     (endgame),
        .phys_start  (phys_start),
        .phys_done   (phys_done),
        .shift_start (shift_start),
        .shift_done  (shift_done),
        .wall_valid  (wall_valid),
        .wall_last   (wall_last),
        .wall_x      (wall_x),
        .wall_y      (wall_y),
        .wall_colour (wall_colour),
        .wall_ready  (wall_ready),
        .dude_valid  (dude_valid),
        .dude_last   (dude_last),
        .dude_x      (dude_x),
        .dude_y      (dude_y),
        .dude_colour (dude_colour),
        .dude_ready  (dude_ready),
        .plot        (plot),
        .plot_x      (plot_x),
        .plot_y      (plot_y),
        .plot_colour (plot_colour),
        .state       (state),
        .frame_count (frame_count),
        .overrun     (overrun)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Edge counter used to time-stamp expected plots
    always @(posedge clk) edgeCount++;

    // Plot monitor: every plot seen on the falling edge must match the
    // oldest expected pixel, including the edge it was due on; a plot with
    // nothing expected is itself an error.
    always @(negedge clk) begin
        if (plot === 1'b1) begin
            compared++;
            if (plotQ.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL unexpectedPlot: got (%0d,%0d) colour %0d at edge %0d, expected no plot",
                         plot_x, plot_y, plot_colour, edgeCount);
            end else begin
                expPix = plotQ.pop_front();
                if (plot_x !== expPix.x || plot_y !== expPix.y ||
                    plot_colour !== expPix.colour || edgeCount != expPix.cycle) begin
                    mismatched++;
                    $display("[TB] FAIL plotBeat: got (%0d,%0d) colour %0d at edge %0d, expected (%0d,%0d) colour %0d at edge %0d",
                             plot_x, plot_y, plot_colour, edgeCount,
                             expPix.x, expPix.y, expPix.colour, expPix.cycle);
                end
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no end of test, expected finish before 500000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic stepN(input int n);
        repeat (n) step();
    endtask

    task automatic applyStimulus(input vec_t v);
        go         = v.go;
        endgame    = v.endgame;
        phys_done  = v.physDone;
        shift_done = v.shiftDone;
    endtask

    task automatic pushPix(input logic [7:0] x, input logic [7:0] y, input logic [2:0] c, input int cyc);
        pix_t p;
        p.x = x; p.y = y; p.colour = c; p.cycle = cyc;
        plotQ.push_back(p);
    endtask

    task automatic waitState(input logic [2:0] target, input int limit);
        int i = 0;
        while (state !== target && i < limit) begin
            step();
            i++;
        end
        if (state !== target) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL waitState: got state %0d after %0d cycles, expected %0d", state, limit, target);
        end
    endtask

    task automatic waitPhysStart(output int at);
        int i = 0;
        while (phys_start !== 1'b1 && i < 200) begin
            step();
            i++;
        end
        at = edgeCount;
        if (phys_start !== 1'b1) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL waitPhysStart: got no phys_start in 200 cycles, expected a pulse");
        end
    endtask

    // Start a game: go high, 12 clear pixels in raster order, then the first
    // tick 32 cycles after entering S_CLEAR.
    task automatic doClear();
        int n;
        n  = edgeCount;
        go = 1'b1;
        for (int y = 0; y < SH; y++)
            for (int x = 0; x < SW; x++)
                pushPix(8'(x), 8'(y), 3'b000, n + 2 + y * SW + x);
        step();
        checkOutput("clearEntryState", state, ST_CLEAR);
        waitState(ST_WAIT, 40);
        checkOutput("clearDoneEdge", edgeCount, n + 13);
        step();
        checkOutput("clearPlotsDrained", plotQ.size(), 0);
        waitPhysStart(tickAt);
        checkOutput("firstTickEdge", tickAt, n + 33);
    endtask

    // From the phys_start cycle: physics and shift each finish 3 cycles later
    task automatic doPhysShift();
        checkOutput("physEntryState", state, ST_PHYS);
        step();
        checkOutput("physStartOneCycle", phys_start, 0);
        step();
        phys_done = 1'b1;
        step();
        phys_done = 1'b0;
        checkOutput("shiftEntryState", state, ST_SHIFT);
        checkOutput("shiftStartPulse", shift_start, 1);
        step();
        checkOutput("shiftStartOneCycle", shift_start, 0);
        step();
        shift_done = 1'b1;
        step();
        shift_done = 1'b0;
        checkOutput("wallEntryState", state, ST_WALL);
        checkOutput("wallReadyInWall", wall_ready, 1);
        checkOutput("dudeReadyInWall", dude_ready, 0);
    endtask

    task automatic streamWall(input int beats, input bit gaps);
        for (int b = 0; b < beats; b++) begin
            wall_valid  = 1'b1;
            wall_x      = 8'(10 + b);
            wall_y      = 8'(20 + 3 * b);
            wall_colour = 3'(b + 1);
            wall_last   = (b == beats - 1);
            pushPix(wall_x, wall_y, wall_colour, edgeCount + 1);
            checkOutput("dudeReadyDuringWall", dude_ready, 0);
            step();
            wall_valid = 1'b0;
            wall_last  = 1'b0;
            if (gaps && b != beats - 1) begin
                checkOutput("dudeReadyDuringWallGap", dude_ready, 0);
                step();
            end
        end
        checkOutput("dudeEntryState", state, ST_DUDE);
        checkOutput("dudeReadyInDude", dude_ready, 1);
        checkOutput("wallReadyInDude", wall_ready, 0);
    endtask

    task automatic streamDude(input int beats, input int expFrames);
        for (int b = 0; b < beats; b++) begin
            dude_valid  = 1'b1;
            dude_x      = 8'(50 + b);
            dude_y      = 8'(60 + b);
            dude_colour = 3'(6 - b);
            dude_last   = (b == beats - 1);
            pushPix(dude_x, dude_y, dude_colour, edgeCount + 1);
            step();
        end
        dude_valid = 1'b0;
        dude_last  = 1'b0;
        checkOutput("frameEndState", state, ST_WAIT);
        checkOutput("frameCount", frame_count, expFrames);
        step();
        checkOutput("framePlotsDrained", plotQ.size(), 0);
    endtask

    // Main sequence
    initial begin
        // cycle-by-cycle endgame vectors, starting on the phys_start cycle
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, ST_PHYS, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, ST_PHYS, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, ST_OVER, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, ST_OVER, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, ST_OVER, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, ST_IDLE, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, ST_IDLE, 1'b0};

        // reset held, then released with go low
        stepN(3);
        checkOutput("resetHeldState", state, ST_IDLE);
        checkOutput("resetHeldPlot", plot, 0);
        reset = 1'b0;
        step();
        checkOutput("resetState", state, ST_IDLE);
        checkOutput("resetPlot", plot, 0);
        checkOutput("resetWallReady", wall_ready, 0);
        checkOutput("resetDudeReady", dude_ready, 0);
        checkOutput("resetFrameCount", frame_count, 0);
        checkOutput("resetOverrun", overrun, 0);
        checkOutput("resetPhysStart", phys_start, 0);
        stepN(2);
        checkOutput("idleWithoutGo", state, ST_IDLE);

        // clear and first full frame
        doClear();
        doPhysShift();
        streamWall(5, 1'b1);
        streamDude(2, 1);
        checkOutput("frame1Overrun", overrun, 0);

        // endgame at phys_done, then leave and restart
        waitPhysStart(tickAt);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i]);
            step();
            checkOutput($sformatf("endgameVecState%0d", i), state, vecs[i].expState);
            checkOutput($sformatf("endgameVecShiftStart%0d", i), shift_start, vecs[i].expShiftStart);
        end
        phys_done  = 1'b0;
        shift_done = 1'b0;
        endgame    = 1'b0;
        checkOutput("endgameFrameCount", frame_count, 1);
        doClear();

        // stalled wall stream lets a tick land in S_WALL
        doPhysShift();
        checkOutput("overrunBeforeStall", overrun, 0);
        stepN(40);
        checkOutput("overrunAfterStall", overrun, 1);
        checkOutput("stallState", state, ST_WALL);
        stepN(10);
        checkOutput("overrunSticky", overrun, 1);
        streamWall(1, 1'b0);
        streamDude(1, 2);
        checkOutput("overrunAfterFrame", overrun, 1);

        // reset pulsed in the middle of S_WALL with a beat in flight
        waitPhysStart(tickAt);
        doPhysShift();
        wall_valid  = 1'b1;
        wall_x      = 8'd77;
        wall_y      = 8'd55;
        wall_colour = 3'd5;
        step();
        checkOutput("plotBeforeReset", plot, 1);
        checkOutput("plotXBeforeReset", plot_x, 77);
        #1;
        go    = 1'b0;
        reset = 1'b1;
        #1;
        checkOutput("plotAtReset", plot, 0);
        checkOutput("stateAtReset", state, ST_IDLE);
        checkOutput("wallReadyAtReset", wall_ready, 0);
        checkOutput("overrunAtReset", overrun, 0);
        checkOutput("frameCountAtReset", frame_count, 0);
        step();
        reset = 1'b0;
        stepN(5);
        checkOutput("postResetState", state, ST_IDLE);
        checkOutput("postResetPlot", plot, 0);
        checkOutput("postResetWallReady", wall_ready, 0);
        wall_valid = 1'b0;
        step();
        checkOutput("scoreboardEmpty", plotQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
